// File: rtl/taurigpu_tl_host.sv
// rtl/taurigpu_tl_host.sv - TL-UL single-beat initiator bridging a req/rsp port to the A/D channels
// One transaction in flight; stray D beats are drained and flagged.
module taurigpu_tl_host #(
  parameter int TL_RS   = 4,
  parameter int AW      = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic             tilelink_clock_i,
  input  logic             tilelink_reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [3:0]       req_mask_i,
  input  logic [31:0]      req_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_error_o,
  output logic             rsp_timeout_o,
  output logic             stray_o,
  output logic [2:0]       tauri_host_a_opcode,
  output logic [2:0]       tauri_host_a_param,
  output logic [3:0]       tauri_host_a_size,
  output logic [TL_RS-1:0] tauri_host_a_source,
  output logic [AW-1:0]    tauri_host_a_address,
  output logic [3:0]       tauri_host_a_mask,
  output logic [31:0]      tauri_host_a_data,
  output logic             tauri_host_a_corrupt,
  output logic             tauri_host_a_valid,
  input  logic             tauri_host_a_ready,
  input  logic [2:0]       tauri_host_d_opcode,
  input  logic [1:0]       tauri_host_d_param,
  input  logic [3:0]       tauri_host_d_size,
  input  logic [TL_RS-1:0] tauri_host_d_source,
  input  logic             tauri_host_d_denied,
  input  logic [31:0]      tauri_host_d_data,
  input  logic             tauri_host_d_corrupt,
  input  logic             tauri_host_d_valid,
  output logic             tauri_host_d_ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_RESP} state_t;

  state_t           state_q, state_d;
  logic [TL_RS-1:0] src_cnt_q;
  logic [TW-1:0]    to_cnt_q;
  logic             is_get_q;
  logic             stray_q;
  logic [31:0]      rsp_data_q;
  logic             rsp_error_q;
  logic             rsp_timeout_q;

  logic req_fire, misaligned, a_fire, d_fire, d_match, d_bad, to_hit;
  logic unused_d;

  assign unused_d   = ^{tauri_host_d_param, tauri_host_d_size};

  assign req_fire   = req_valid_i && req_ready_o;
  assign misaligned = req_addr_i[1:0] != 2'b00;
  assign a_fire     = tauri_host_a_valid && tauri_host_a_ready;
  assign d_fire     = tauri_host_d_valid && tauri_host_d_ready;
  assign d_match    = (state_q == ST_WAIT) && tauri_host_d_valid &&
                      (tauri_host_d_source == tauri_host_a_source);
  // Get expects AccessAckData (1), Put expects AccessAck (0)
  assign d_bad      = tauri_host_d_denied ||
                      (tauri_host_d_opcode != (is_get_q ? 3'd1 : 3'd0)) ||
                      (is_get_q && tauri_host_d_corrupt);
  assign to_hit     = (state_q == ST_WAIT) && !d_match && (to_cnt_q == TW'(TIMEOUT - 1));

  assign rsp_data_o    = rsp_data_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign stray_o       = stray_q;

  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    req_ready_o        = 1'b0;
    tauri_host_a_valid = 1'b0;
    tauri_host_d_ready = 1'b1;
    rsp_valid_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = misaligned ? ST_RESP : ST_ADDR;
      end
      ST_ADDR: begin
        tauri_host_a_valid = 1'b1;
        tauri_host_d_ready = 1'b0;
        if (tauri_host_a_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (d_match || to_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tilelink_clock_i) begin
    if (tilelink_reset_i) begin
      src_cnt_q            <= '0;
      to_cnt_q             <= '0;
      is_get_q             <= 1'b0;
      stray_q              <= 1'b0;
      rsp_data_q           <= '0;
      rsp_error_q          <= 1'b0;
      rsp_timeout_q        <= 1'b0;
      tauri_host_a_opcode  <= '0;
      tauri_host_a_param   <= '0;
      tauri_host_a_size    <= '0;
      tauri_host_a_source  <= '0;
      tauri_host_a_address <= '0;
      tauri_host_a_mask    <= '0;
      tauri_host_a_data    <= '0;
      tauri_host_a_corrupt <= 1'b0;
    end else begin
      // Anything accepted that is not the awaited reply is dropped and flagged
      stray_q <= d_fire && !d_match;

      if (req_fire) begin
        if (req_write_i) begin
          tauri_host_a_opcode <= (req_mask_i == 4'hF) ? 3'd0 : 3'd1;
          tauri_host_a_mask   <= req_mask_i;
          tauri_host_a_data   <= req_data_i;
        end else begin
          tauri_host_a_opcode <= 3'd4;
          tauri_host_a_mask   <= 4'hF;
          tauri_host_a_data   <= '0;
        end
        tauri_host_a_param   <= '0;
        tauri_host_a_size    <= 4'd2;
        tauri_host_a_corrupt <= 1'b0;
        tauri_host_a_address <= req_addr_i;
        tauri_host_a_source  <= src_cnt_q;
        is_get_q             <= !req_write_i;
        rsp_data_q           <= '0;
        rsp_error_q          <= misaligned;
        rsp_timeout_q        <= 1'b0;
      end

      if (a_fire) begin
        src_cnt_q <= src_cnt_q + TL_RS'(1);
        to_cnt_q  <= '0;
      end else if (state_q == ST_WAIT) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      if (d_match) begin
        rsp_error_q <= d_bad;
        rsp_data_q  <= (is_get_q && !d_bad) ? tauri_host_d_data : 32'd0;
      end else if (to_hit) begin
        rsp_error_q   <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

endmodule
